pmp_access_ctrl: RTL and testbench

Sequencing front-end for the combinational PMP checker (`PMP`). It accepts one memory request at a time from the fetch/LSU side over a valid/ready handshake and registers it. It then drives the checker's `io_req`/`io_addr`/`io_size`/`io_r/w/x`/`io_prv` inputs for one cycle and samples `io_exception`. Depending on the result, it either forwards the request to the memory bus or reports an access fault with RISC-V cause and tval.

---
 rtl/pmp_pkg.sv | 32 +++
 rtl/pmp_align_check.sv | 39 +++
 rtl/pmp_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pmp_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP access-control front-end:
// pmpcfg layout, address-match modes, privilege levels, fault causes and FSM states.
package pmp_pkg;

    typedef struct packed {
        logic       l;
        logic [1:0] res;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [1:0] A0_OFF   = 2'd0;
    localparam logic [1:0] A1_TOR   = 2'd1;
    localparam logic [1:0] A2_NA4   = 2'd2;
    localparam logic [1:0] A3_NAPOT = 2'd3;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

    localparam logic [3:0] MISALIGN_FETCH = 4'd0;
    localparam logic [3:0] ACCESS_FETCH   = 4'd1;
    localparam logic [3:0] MISALIGN_LOAD  = 4'd4;
    localparam logic [3:0] ACCESS_LOAD    = 4'd5;
    localparam logic [3:0] MISALIGN_STORE = 4'd6;
    localparam logic [3:0] ACCESS_STORE   = 4'd7;

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, FAULT} state_e;

endpackage

// File: rtl/pmp_align_check.sv
// Combinational natural-alignment test for a registered request plus selection of
// the RISC-V fault cause (misalignment outranks a PMP denial; store > fetch > load).
module pmp_align_check
    import pmp_pkg::*;
(
    input  logic [2:0] addr_lo_i,
    input  logic [1:0] size_i,
    input  logic       w_i,
    input  logic       x_i,
    input  logic       exception_i,
    output logic       misaligned_o,
    output logic       fault_o,
    output logic [3:0] cause_o
);

    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            2'd1:    misaligned_o = addr_lo_i[0];
            2'd2:    misaligned_o = |addr_lo_i[1:0];
            2'd3:    misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        cause_o = ACCESS_LOAD;
        if (w_i) begin
            cause_o = misaligned_o ? MISALIGN_STORE : ACCESS_STORE;
        end else if (x_i) begin
            cause_o = misaligned_o ? MISALIGN_FETCH : ACCESS_FETCH;
        end else begin
            cause_o = misaligned_o ? MISALIGN_LOAD : ACCESS_LOAD;
        end
    end

    assign fault_o = misaligned_o | exception_i;

endmodule

// File: rtl/pmp_access_ctrl.sv
// Sequencer that registers one request, runs it through the PMP checker for a cycle,
// then issues it to memory or raises an access fault. Option: PMP_FAULT_CNT_EN adds io_fault_cnt.
module pmp_access_ctrl
    import pmp_pkg::*;
#(
    parameter int         PLEN   = 33,
    parameter logic [1:0] U_MODE = PRV_U,
    parameter logic [1:0] S_MODE = PRV_S,
    parameter logic [1:0] M_MODE = PRV_M
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [PLEN:0]   io_in_addr,
    input  logic [1:0]      io_in_size,
    input  logic            io_in_r,
    input  logic            io_in_w,
    input  logic            io_in_x,
    input  logic [1:0]      io_in_prv,
    input  logic            io_flush,
    output logic            io_pmp_req,
    output logic [PLEN:0]   io_pmp_addr,
    output logic [1:0]      io_pmp_size,
    output logic            io_pmp_r,
    output logic            io_pmp_w,
    output logic            io_pmp_x,
    output logic [1:0]      io_pmp_prv,
    input  logic            io_pmp_exception,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [PLEN:0]   io_out_addr,
    output logic [1:0]      io_out_size,
    output logic            io_out_we,
    output logic            io_out_fetch,
    output logic            io_fault_valid,
    output logic [3:0]      io_fault_cause,
    output logic [PLEN:0]   io_fault_tval
`ifdef PMP_FAULT_CNT_EN
    ,
    output logic [15:0]     io_fault_cnt
`endif
);

    state_e        state_q;
    logic [PLEN:0] addr_q;
    logic [1:0]    size_q;
    logic          r_q;
    logic          w_q;
    logic          x_q;
    logic [1:0]    prv_q;
    logic [3:0]    cause_q;

    logic          chk_misaligned;
    logic          chk_fault;
    logic [3:0]    chk_cause;

    // Privilege encodings must stay distinct or the checker cannot tell modes apart.
    if ((U_MODE == S_MODE) || (S_MODE == M_MODE) || (U_MODE == M_MODE)) begin : g_prv_clash
    end

    pmp_align_check u_align (
        .addr_lo_i    (addr_q[2:0]),
        .size_i       (size_q),
        .w_i          (w_q),
        .x_i          (x_q),
        .exception_i  (io_pmp_exception),
        .misaligned_o (chk_misaligned),
        .fault_o      (chk_fault),
        .cause_o      (chk_cause)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            r_q     <= 1'b0;
            w_q     <= 1'b0;
            x_q     <= 1'b0;
            prv_q   <= U_MODE;
            cause_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io_in_valid && io_in_ready) begin
                        addr_q  <= io_in_addr;
                        size_q  <= io_in_size;
                        r_q     <= io_in_r;
                        w_q     <= io_in_w;
                        x_q     <= io_in_x;
                        prv_q   <= io_in_prv;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // The checker verdict is only trusted here, while io_pmp_req is high.
                    if (io_flush) begin
                        state_q <= IDLE;
                    end else if (chk_fault) begin
                        cause_q <= chk_cause;
                        state_q <= FAULT;
                    end else begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (io_out_ready) begin
                        state_q <= IDLE;
                    end
                end
                FAULT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_in_ready    = (state_q == IDLE) && !io_flush;

    assign io_pmp_req     = (state_q == CHECK);
    assign io_pmp_addr    = addr_q;
    assign io_pmp_size    = size_q;
    assign io_pmp_r       = r_q;
    assign io_pmp_w       = w_q;
    assign io_pmp_x       = x_q;
    assign io_pmp_prv     = prv_q;

    assign io_out_valid   = (state_q == ISSUE);
    assign io_out_addr    = addr_q;
    assign io_out_size    = size_q;
    assign io_out_we      = w_q;
    assign io_out_fetch   = x_q & ~w_q;

    assign io_fault_valid = (state_q == FAULT);
    assign io_fault_cause = cause_q;
    assign io_fault_tval  = addr_q;

`ifdef PMP_FAULT_CNT_EN
    logic [15:0] fault_cnt_q;
    logic [15:0] fault_cnt_d;

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if ((state_q == FAULT) && (fault_cnt_q != 16'hFFFF)) begin
            fault_cnt_d = fault_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign io_fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_pmp_access_ctrl.sv
// Randomised scoreboard bench for pmp_access_ctrl: a driver pushes the expected outcome of
// each request, a monitor pops and compares whenever an out or fault is presented.
module tb_pmp_access_ctrl;

    localparam int PLEN = 33;
    typedef logic [PLEN:0] addr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    addr_t       io_in_addr = '0;
    logic [1:0]  io_in_size = '0;
    logic        io_in_r = 1'b0, io_in_w = 1'b0, io_in_x = 1'b0;
    logic [1:0]  io_in_prv = '0;
    logic        io_flush = 1'b0;
    logic        io_pmp_req;
    addr_t       io_pmp_addr;
    logic [1:0]  io_pmp_size;
    logic        io_pmp_r, io_pmp_w, io_pmp_x;
    logic [1:0]  io_pmp_prv;
    logic        io_pmp_exception = 1'b0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b1;
    addr_t       io_out_addr;
    logic [1:0]  io_out_size;
    logic        io_out_we, io_out_fetch;
    logic        io_fault_valid;
    logic [3:0]  io_fault_cause;
    addr_t       io_fault_tval;
`ifdef PMP_FAULT_CNT_EN
    logic [15:0] io_fault_cnt;
`endif

    pmp_access_ctrl #(.PLEN(PLEN)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (io_in_valid),
        .io_in_ready      (io_in_ready),
        .io_in_addr       (io_in_addr),
        .io_in_size       (io_in_size),
        .io_in_r          (io_in_r),
        .io_in_w          (io_in_w),
        .io_in_x          (io_in_x),
        .io_in_prv        (io_in_prv),
        .io_flush         (io_flush),
        .io_pmp_req       (io_pmp_req),
        .io_pmp_addr      (io_pmp_addr),
        .io_pmp_size      (io_pmp_size),
        .io_pmp_r         (io_pmp_r),
        .io_pmp_w         (io_pmp_w),
        .io_pmp_x         (io_pmp_x),
        .io_pmp_prv       (io_pmp_prv),
        .io_pmp_exception (io_pmp_exception),
        .io_out_valid     (io_out_valid),
        .io_out_ready     (io_out_ready),
        .io_out_addr      (io_out_addr),
        .io_out_size      (io_out_size),
        .io_out_we        (io_out_we),
        .io_out_fetch     (io_out_fetch),
        .io_fault_valid   (io_fault_valid),
        .io_fault_cause   (io_fault_cause),
        .io_fault_tval    (io_fault_tval)
`ifdef PMP_FAULT_CNT_EN
        ,
        .io_fault_cnt     (io_fault_cnt)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_fault;
        logic [3:0] cause;
        addr_t      addr;
        logic [1:0] size;
        bit         we;
        bit         fetch;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   faults_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference outcome from the architectural rules: natural alignment by modulo,
    // access class store > fetch > load, misalignment outranks a PMP denial.
    function automatic exp_t model(input addr_t a, input logic [1:0] sz, input logic w,
                                   input logic x, input logic exc);
        exp_t        e;
        int unsigned nbytes;
        bit          mis;
        int          kind;
        int          mis_code[3] = '{0, 4, 6};
        int          acc_code[3] = '{1, 5, 7};
        nbytes     = 1 << sz;
        mis        = (64'(a) % 64'(nbytes)) != 0;
        kind       = w ? 2 : (x ? 0 : 1);
        e.addr     = a;
        e.size     = sz;
        e.we       = w;
        e.fetch    = x && !w;
        e.is_fault = mis || exc;
        e.cause    = mis ? 4'(mis_code[kind]) : 4'(acc_code[kind]);
        e.cyc      = 0;
        return e;
    endfunction

    bit hold_ready = 1'b0;
    bit rand_ready = 1'b0;
    always @(posedge clock) begin
        #1;
        if (hold_ready)      io_out_ready = 1'b0;
        else if (rand_ready) io_out_ready = ($urandom % 4) != 0;
        else                 io_out_ready = 1'b1;
    end

    bit   mon_out_busy = 1'b0;
    bit   prev_fault = 1'b0;
    bit   after_done = 1'b0;
    exp_t cur;

    always @(negedge clock) begin
        #2;
        if (reset) begin
            mon_out_busy = 1'b0;
            prev_fault   = 1'b0;
            after_done   = 1'b0;
            faults_seen  = 0;
            sbq.delete();
        end else begin
            if (after_done) chk("idle_after_done", io_in_ready, !io_flush);
            after_done = 1'b0;
            if (io_fault_valid) begin
                chk("fault_single_pulse", prev_fault, 0);
                chk("sb_has_fault", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    cur = sbq.pop_front();
                    chk("fault_expected", 1, cur.is_fault);
                    chk("fault_cause", io_fault_cause, cur.cause);
                    chk("fault_tval", io_fault_tval, cur.addr);
                    chk("fault_latency", cyc, cur.cyc);
                    chk("fault_no_out", io_out_valid, 0);
                end
                faults_seen++;
                after_done = 1'b1;
            end
            prev_fault = io_fault_valid;
            if (io_out_valid) begin
                if (!mon_out_busy) begin
                    chk("sb_has_out", sbq.size() > 0, 1);
                    if (sbq.size() > 0) begin
                        cur = sbq.pop_front();
                        chk("out_expected", 0, cur.is_fault);
                        chk("out_latency", cyc, cur.cyc);
                    end
                end
                chk("out_addr", io_out_addr, cur.addr);
                chk("out_size", io_out_size, cur.size);
                chk("out_we", io_out_we, cur.we);
                chk("out_fetch", io_out_fetch, cur.fetch);
                chk("in_ready_busy", io_in_ready, 0);
                mon_out_busy = !io_out_ready;
                if (io_out_ready) after_done = 1'b1;
            end
        end
    end

    task automatic do_req(input addr_t a, input logic [1:0] sz, input logic r, input logic w,
                          input logic x, input logic [1:0] prv, input logic exc, input logic fl);
        int   g;
        exp_t e;
        @(negedge clock);
        io_flush    = 1'b0;
        io_in_valid = 1'b1;
        io_in_addr  = a;
        io_in_size  = sz;
        io_in_r     = r;
        io_in_w     = w;
        io_in_x     = x;
        io_in_prv   = prv;
        g = 0;
        #1;
        while (!io_in_ready && g < 200) begin
            @(negedge clock);
            #1;
            g++;
        end
        chk("accept_in_time", g < 200, 1);
        @(negedge clock);
        io_in_valid      = 1'b0;
        io_pmp_exception = exc;
        io_flush         = fl;
        #1;
        chk("pmp_req_check", io_pmp_req, 1);
        chk("pmp_addr", io_pmp_addr, a);
        chk("pmp_size", io_pmp_size, sz);
        chk("pmp_type", {io_pmp_r, io_pmp_w, io_pmp_x}, {r, w, x});
        chk("pmp_prv", io_pmp_prv, prv);
        if (!fl) begin
            e     = model(a, sz, w, x, exc);
            e.cyc = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clock);
        #1;
        chk("pmp_req_off", io_pmp_req, 0);
        io_pmp_exception = 1'($urandom);
        io_flush         = fl ? 1'b0 : (($urandom % 4) == 0);
    endtask

    initial begin
        int    g;
        addr_t ra;
        logic [1:0] prvs[3] = '{2'b00, 2'b01, 2'b11};

        repeat (3) @(negedge clock);
        #1;
        chk("rst_in_ready", io_in_ready, 1);
        chk("rst_pmp_req", io_pmp_req, 0);
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_fault_valid", io_fault_valid, 0);
        chk("rst_fault_cause", io_fault_cause, 0);
        chk("rst_fault_tval", io_fault_tval, 0);
        chk("rst_out_addr", io_out_addr, 0);
        chk("rst_pmp_size", io_pmp_size, 0);
        chk("rst_pmp_type", {io_pmp_r, io_pmp_w, io_pmp_x}, 0);
        @(negedge clock);
        reset = 1'b0;

        // Reset while a legal load is stuck in ISSUE drops it.
        hold_ready = 1'b1;
        do_req(34'h3000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("pre_reset_issue", io_out_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("reset_drops_out", io_out_valid, 0);
        chk("reset_in_ready", io_in_ready, !io_flush);
        io_flush = 1'b0;
        reset = 1'b0;
        hold_ready = 1'b0;

        do_req(34'h1000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        do_req(34'h2000, 2'd3, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        do_req(34'h1002, 2'd2, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
        do_req(34'h0003, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

        // Stall with flush and a competing request present: nothing may move.
        hold_ready = 1'b1;
        do_req(34'h2_0000_4000, 2'd3, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        io_in_valid = 1'b1;
        io_in_addr  = 34'h5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            io_flush = 1'b1;
            #1;
            chk("stall_valid", io_out_valid, 1);
            chk("stall_in_ready", io_in_ready, 0);
        end
        io_in_valid = 1'b0;
        hold_ready  = 1'b0;

        do_req(34'h5000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("flush_no_out", io_out_valid, 0);
        chk("flush_no_fault", io_fault_valid, 0);

        rand_ready = 1'b1;
        for (int n = 0; n < 250; n++) begin
            ra = {2'($urandom), $urandom};
            do_req(ra, 2'($urandom), 1'($urandom), (($urandom % 3) == 0), 1'($urandom),
                   prvs[$urandom % 3], (($urandom % 3) == 0), (($urandom % 8) == 0));
        end

        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", sbq.size(), 0);
`ifdef PMP_FAULT_CNT_EN
        #1;
        chk("fault_cnt", io_fault_cnt, 16'(faults_seen));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
